// File: rtl/tcm_mem_pipe.sv
// Purpose: TCM with a fetch port and a data port over one true-dual-port RAM. Define TCM_MEM_PARITY_EN to add per-byte parity.
// Latency: both ports respond exactly RD_LATENCY cycles after a request, in order.
// Backpressure: none; each port accepts one request per cycle.
module tcm_mem_pipe #(
    parameter int ADDR_W     = 16,
    parameter int INST_W     = 64,
    parameter int RD_LATENCY = 1,
    parameter int TAG_W      = 11
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              mem_i_rd_i,
    input  logic              mem_i_flush_i,
    input  logic              mem_i_invalidate_i,
    input  logic [31:0]       mem_i_pc_i,
    output logic              mem_i_accept_o,
    output logic              mem_i_valid_o,
    output logic              mem_i_error_o,
    output logic [INST_W-1:0] mem_i_inst_o,
    input  logic [31:0]       mem_d_addr_i,
    input  logic [31:0]       mem_d_data_wr_i,
    input  logic              mem_d_rd_i,
    input  logic [3:0]        mem_d_wr_i,
    input  logic              mem_d_cacheable_i,
    input  logic [TAG_W-1:0]  mem_d_req_tag_i,
    input  logic              mem_d_invalidate_i,
    input  logic              mem_d_writeback_i,
    input  logic              mem_d_flush_i,
`ifdef TCM_MEM_PARITY_EN
    input  logic              mem_inject_par_i,
`endif
    output logic              mem_d_accept_o,
    output logic              mem_d_ack_o,
    output logic              mem_d_error_o,
    output logic [31:0]       mem_d_data_rd_o,
    output logic [TAG_W-1:0]  mem_d_resp_tag_o
);
    localparam int NB    = INST_W / 8;
    localparam int WB    = (INST_W == 64) ? 3 : 2;
    localparam int IW    = ADDR_W - WB;
    localparam int DEPTH = 2 ** IW;

    logic [INST_W-1:0] ram [DEPTH];

    logic              d_req, d_access, d_oor, i_oor, d_we, d_lane;
    logic [IW-1:0]     d_idx, i_idx;
    logic [NB-1:0]     d_be;
    logic [INST_W-1:0] d_wdat;

    assign mem_i_accept_o = 1'b1;
    assign mem_d_accept_o = 1'b1;

    assign d_access = mem_d_rd_i | (|mem_d_wr_i);
    assign d_req    = d_access | mem_d_flush_i | mem_d_invalidate_i | mem_d_writeback_i;
    assign d_oor    = |mem_d_addr_i[31:ADDR_W];
    assign i_oor    = |mem_i_pc_i[31:ADDR_W];
    assign d_we     = ~d_oor & (|mem_d_wr_i);
    assign d_idx    = mem_d_addr_i[ADDR_W-1:WB];
    assign i_idx    = mem_i_pc_i[ADDR_W-1:WB];

    logic unused_ok;
    assign unused_ok = ^{mem_i_invalidate_i, mem_d_cacheable_i, mem_d_addr_i[2:0], mem_i_pc_i[WB-1:0]};

    // addr[2]==0 maps to the upper half of a 64-bit fetch word
    if (INST_W == 64) begin : g_lane64
        assign d_lane = mem_d_addr_i[2];
        assign d_be   = d_lane ? {4'b0000, mem_d_wr_i} : {mem_d_wr_i, 4'b0000};
        assign d_wdat = {mem_d_data_wr_i, mem_d_data_wr_i};
    end else begin : g_lane32
        assign d_lane = 1'b0;
        assign d_be   = mem_d_wr_i;
        assign d_wdat = mem_d_data_wr_i;
    end

    always_ff @(posedge clk_i) begin
        if (d_we) begin
            for (int b = 0; b < NB; b++) begin
                if (d_be[b]) ram[d_idx][8*b +: 8] <= d_wdat[8*b +: 8];
            end
        end
    end

    // Stage 1: registered RAM reads; both ports see pre-write contents
    logic              d_v1, d_oor1, d_lane1, i_v1, i_oor1;
    logic [TAG_W-1:0]  d_tag1;
    logic [INST_W-1:0] d_word1, i_word1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            d_v1    <= 1'b0;
            d_oor1  <= 1'b0;
            d_lane1 <= 1'b0;
            d_tag1  <= '0;
            d_word1 <= '0;
            i_v1    <= 1'b0;
            i_oor1  <= 1'b0;
            i_word1 <= '0;
        end else begin
            d_v1 <= d_req;
            i_v1 <= mem_i_rd_i;
            if (d_req) begin
                d_oor1  <= d_oor & d_access;
                d_lane1 <= d_lane;
                d_tag1  <= mem_d_req_tag_i;
                d_word1 <= d_oor ? '0 : ram[d_idx];
            end
            if (mem_i_rd_i) begin
                i_oor1  <= i_oor;
                i_word1 <= i_oor ? '0 : ram[i_idx];
            end
        end
    end

    logic d_perr1, i_perr1;
`ifdef TCM_MEM_PARITY_EN
    logic [NB-1:0] par_ram [DEPTH];
    logic [NB-1:0] d_pw1, i_pw1, d_mis, i_mis;
    logic [3:0]    d_lane_mis;
    logic          d_chk1, i_chk1;

    always_ff @(posedge clk_i) begin
        if (d_we) begin
            for (int b = 0; b < NB; b++) begin
                if (d_be[b]) par_ram[d_idx][b] <= (^d_wdat[8*b +: 8]) ^ mem_inject_par_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            d_chk1 <= 1'b0;
            d_pw1  <= '0;
            i_chk1 <= 1'b0;
            i_pw1  <= '0;
        end else begin
            if (d_req) begin
                d_chk1 <= mem_d_rd_i & ~d_oor;
                d_pw1  <= par_ram[d_idx];
            end
            if (mem_i_rd_i) begin
                i_chk1 <= ~i_oor;
                i_pw1  <= par_ram[i_idx];
            end
        end
    end

    always_comb begin
        d_mis = '0;
        i_mis = '0;
        for (int b = 0; b < NB; b++) begin
            d_mis[b] = (^d_word1[8*b +: 8]) ^ d_pw1[b];
            i_mis[b] = (^i_word1[8*b +: 8]) ^ i_pw1[b];
        end
    end

    assign d_lane_mis = (INST_W == 64 && !d_lane1) ? d_mis[NB-1 -: 4] : d_mis[3:0];
    assign d_perr1    = d_chk1 & (|d_lane_mis);
    assign i_perr1    = i_chk1 & (|i_mis);
`else
    assign d_perr1 = 1'b0;
    assign i_perr1 = 1'b0;
`endif

    logic        d_err1, i_err1;
    logic [31:0] d_dat1;
    assign d_err1 = d_oor1 | d_perr1;
    assign i_err1 = i_oor1 | i_perr1;
    assign d_dat1 = (INST_W == 64 && !d_lane1) ? d_word1[INST_W-1 -: 32] : d_word1[31:0];

    if (RD_LATENCY == 1) begin : g_lat1
        assign mem_d_ack_o      = d_v1;
        assign mem_d_error_o    = d_err1;
        assign mem_d_resp_tag_o = d_tag1;
        assign mem_d_data_rd_o  = d_dat1;
        assign mem_i_valid_o    = i_v1 & ~mem_i_flush_i;
        assign mem_i_error_o    = i_err1;
        assign mem_i_inst_o     = i_word1;
    end else begin : g_latn
        logic [RD_LATENCY:2] d_v, d_e, i_v, i_e;
        logic [TAG_W-1:0]    d_t [2:RD_LATENCY];
        logic [31:0]         d_d [2:RD_LATENCY];
        logic [INST_W-1:0]   i_d [2:RD_LATENCY];

        // Data stages only advance with a valid entry, so outputs hold the last response
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                d_v <= '0;
                d_e <= '0;
                i_v <= '0;
                i_e <= '0;
                for (int k = 2; k <= RD_LATENCY; k++) begin
                    d_t[k] <= '0;
                    d_d[k] <= '0;
                    i_d[k] <= '0;
                end
            end else begin
                d_v[2] <= d_v1;
                i_v[2] <= i_v1 & ~mem_i_flush_i;
                if (d_v1) begin
                    d_e[2] <= d_err1;
                    d_t[2] <= d_tag1;
                    d_d[2] <= d_dat1;
                end
                if (i_v1 && !mem_i_flush_i) begin
                    i_e[2] <= i_err1;
                    i_d[2] <= i_word1;
                end
                for (int k = 3; k <= RD_LATENCY; k++) begin
                    d_v[k] <= d_v[k-1];
                    i_v[k] <= i_v[k-1] & ~mem_i_flush_i;
                    if (d_v[k-1]) begin
                        d_e[k] <= d_e[k-1];
                        d_t[k] <= d_t[k-1];
                        d_d[k] <= d_d[k-1];
                    end
                    if (i_v[k-1] && !mem_i_flush_i) begin
                        i_e[k] <= i_e[k-1];
                        i_d[k] <= i_d[k-1];
                    end
                end
            end
        end

        assign mem_d_ack_o      = d_v[RD_LATENCY];
        assign mem_d_error_o    = d_e[RD_LATENCY];
        assign mem_d_resp_tag_o = d_t[RD_LATENCY];
        assign mem_d_data_rd_o  = d_d[RD_LATENCY];
        assign mem_i_valid_o    = i_v[RD_LATENCY] & ~mem_i_flush_i;
        assign mem_i_error_o    = i_e[RD_LATENCY];
        assign mem_i_inst_o     = i_d[RD_LATENCY];
    end
endmodule

// File: tb/tb_tcm_mem_pipe.sv
// Directed bench for tcm_mem_pipe at RD_LATENCY=3, INST_W=64, ADDR_W=16.
module tb_tcm_mem_pipe;
    localparam int LAT    = 3;
    localparam int TAG_W  = 11;
    localparam int INST_W = 64;
    localparam int ADDR_W = 16;

    logic              clk_i = 1'b0;
    logic              rstn_i = 1'b1;
    logic              mem_i_rd_i = 1'b0, mem_i_flush_i = 1'b0, mem_i_invalidate_i = 1'b0;
    logic [31:0]       mem_i_pc_i = '0;
    logic              mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
    logic [INST_W-1:0] mem_i_inst_o;
    logic [31:0]       mem_d_addr_i = '0, mem_d_data_wr_i = '0;
    logic              mem_d_rd_i = 1'b0;
    logic [3:0]        mem_d_wr_i = '0;
    logic              mem_d_cacheable_i = 1'b0;
    logic [TAG_W-1:0]  mem_d_req_tag_i = '0;
    logic              mem_d_invalidate_i = 1'b0, mem_d_writeback_i = 1'b0, mem_d_flush_i = 1'b0;
`ifdef TCM_MEM_PARITY_EN
    logic              mem_inject_par_i = 1'b0;
`endif
    logic              mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
    logic [31:0]       mem_d_data_rd_o;
    logic [TAG_W-1:0]  mem_d_resp_tag_o;

    int n_chk = 0;
    int n_err = 0;

    tcm_mem_pipe #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RD_LATENCY(LAT), .TAG_W(TAG_W)) u_dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .mem_i_rd_i         (mem_i_rd_i),
        .mem_i_flush_i      (mem_i_flush_i),
        .mem_i_invalidate_i (mem_i_invalidate_i),
        .mem_i_pc_i         (mem_i_pc_i),
        .mem_i_accept_o     (mem_i_accept_o),
        .mem_i_valid_o      (mem_i_valid_o),
        .mem_i_error_o      (mem_i_error_o),
        .mem_i_inst_o       (mem_i_inst_o),
        .mem_d_addr_i       (mem_d_addr_i),
        .mem_d_data_wr_i    (mem_d_data_wr_i),
        .mem_d_rd_i         (mem_d_rd_i),
        .mem_d_wr_i         (mem_d_wr_i),
        .mem_d_cacheable_i  (mem_d_cacheable_i),
        .mem_d_req_tag_i    (mem_d_req_tag_i),
        .mem_d_invalidate_i (mem_d_invalidate_i),
        .mem_d_writeback_i  (mem_d_writeback_i),
        .mem_d_flush_i      (mem_d_flush_i),
`ifdef TCM_MEM_PARITY_EN
        .mem_inject_par_i   (mem_inject_par_i),
`endif
        .mem_d_accept_o     (mem_d_accept_o),
        .mem_d_ack_o        (mem_d_ack_o),
        .mem_d_error_o      (mem_d_error_o),
        .mem_d_data_rd_o    (mem_d_data_rd_o),
        .mem_d_resp_tag_o   (mem_d_resp_tag_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        mem_d_rd_i    = 1'b0;
        mem_d_wr_i    = 4'h0;
        mem_d_flush_i = 1'b0;
        mem_i_rd_i    = 1'b0;
        mem_i_flush_i = 1'b0;
    endtask

    task automatic d_req(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                         input logic [31:0] wdat, input logic [TAG_W-1:0] tag);
        mem_d_rd_i      = rd;
        mem_d_wr_i      = wr;
        mem_d_addr_i    = addr;
        mem_d_data_wr_i = wdat;
        mem_d_req_tag_i = tag;
    endtask

    // Issue one data request and advance until its response is on the outputs
    task automatic d_op(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                        input logic [31:0] wdat, input logic [TAG_W-1:0] tag);
        d_req(rd, wr, addr, wdat, tag);
        tick(1);
        idle();
        tick(LAT - 1);
    endtask

    task automatic i_op(input logic [31:0] pc);
        mem_i_rd_i = 1'b1;
        mem_i_pc_i = pc;
        tick(1);
        idle();
        tick(LAT - 1);
    endtask

    initial begin
        #2 rstn_i = 1'b0;
        #1;
        check("rst_ack",    64'(mem_d_ack_o),      64'd0);
        check("rst_valid",  64'(mem_i_valid_o),    64'd0);
        check("rst_derr",   64'(mem_d_error_o),    64'd0);
        check("rst_ierr",   64'(mem_i_error_o),    64'd0);
        check("rst_dat",    64'(mem_d_data_rd_o),  64'd0);
        check("rst_inst",   mem_i_inst_o,          64'd0);
        check("rst_tag",    64'(mem_d_resp_tag_o), 64'd0);
        check("rst_dacc",   64'(mem_d_accept_o),   64'd1);
        check("rst_iacc",   64'(mem_i_accept_o),   64'd1);
        tick(2);
        rstn_i = 1'b1;
        tick(1);

        // Pipelined write then read of 0x104
        d_req(1'b0, 4'hF, 32'h104, 32'hDEADBEEF, 11'd5);
        tick(1);
        d_req(1'b1, 4'h0, 32'h104, 32'h0, 11'd6);
        tick(1);
        idle();
        check("t1_early_ack", 64'(mem_d_ack_o), 64'd0);
        tick(1);
        check("t1_wr_ack", 64'(mem_d_ack_o),      64'd1);
        check("t1_wr_tag", 64'(mem_d_resp_tag_o), 64'd5);
        check("t1_wr_err", 64'(mem_d_error_o),    64'd0);
        tick(1);
        check("t1_rd_ack", 64'(mem_d_ack_o),      64'd1);
        check("t1_rd_tag", 64'(mem_d_resp_tag_o), 64'd6);
        check("t1_rd_dat", 64'(mem_d_data_rd_o),  64'hDEADBEEF);
        tick(1);
        check("t1_idle_ack", 64'(mem_d_ack_o),     64'd0);
        check("t1_hold_dat", 64'(mem_d_data_rd_o), 64'hDEADBEEF);

        // Byte strobe into a cleared word
        d_op(1'b0, 4'hF, 32'h8, 32'h0, 11'd1);
        d_op(1'b0, 4'hF, 32'hC, 32'h0, 11'd1);
        d_op(1'b0, 4'h2, 32'h8, 32'h11223344, 11'd2);
        d_op(1'b1, 4'h0, 32'h8, 32'h0, 11'd3);
        check("t2_rd_dat", 64'(mem_d_data_rd_o),  64'h00003300);
        check("t2_rd_tag", 64'(mem_d_resp_tag_o), 64'd3);
        i_op(32'h8);
        check("t2_f_valid", 64'(mem_i_valid_o), 64'd1);
        check("t2_f_inst",  mem_i_inst_o,       64'h0000330000000000);
        check("t2_f_err",   64'(mem_i_error_o), 64'd0);

        // Out-of-range accesses
        d_op(1'b0, 4'hF, 32'h0, 32'h01020304, 11'd4);
        d_op(1'b0, 4'hF, 32'h10000, 32'hCAFEF00D, 11'd7);
        check("t3_oor_ack", 64'(mem_d_ack_o),      64'd1);
        check("t3_oor_err", 64'(mem_d_error_o),    64'd1);
        check("t3_oor_tag", 64'(mem_d_resp_tag_o), 64'd7);
        d_op(1'b1, 4'h0, 32'h0, 32'h0, 11'd8);
        check("t3_keep_dat", 64'(mem_d_data_rd_o), 64'h01020304);
        check("t3_keep_err", 64'(mem_d_error_o),   64'd0);
        d_op(1'b1, 4'h0, 32'h10000, 32'h0, 11'd9);
        check("t3_rd_err", 64'(mem_d_error_o),   64'd1);
        check("t3_rd_dat", 64'(mem_d_data_rd_o), 64'd0);
        i_op(32'h10000);
        check("t3_f_valid", 64'(mem_i_valid_o), 64'd1);
        check("t3_f_err",   64'(mem_i_error_o), 64'd1);
        mem_d_addr_i    = 32'h10000;
        mem_d_req_tag_i = 11'd10;
        mem_d_flush_i   = 1'b1;
        tick(1);
        idle();
        tick(LAT - 1);
        check("t3_cop_ack", 64'(mem_d_ack_o),   64'd1);
        check("t3_cop_err", 64'(mem_d_error_o), 64'd0);

        // Fetch flush: only the fetch issued in the flush cycle survives
        d_op(1'b0, 4'hF, 32'h10, 32'hA5A5A5A5, 11'd0);
        d_op(1'b0, 4'hF, 32'h14, 32'h5A5A5A5A, 11'd0);
        mem_i_rd_i = 1'b1;
        mem_i_pc_i = 32'h0;
        d_req(1'b1, 4'h0, 32'h0, 32'h0, 11'd12);
        tick(1);
        idle();
        mem_i_rd_i = 1'b1;
        mem_i_pc_i = 32'h8;
        tick(1);
        mem_i_pc_i    = 32'h10;
        mem_i_flush_i = 1'b1;
        tick(1);
        idle();
        check("t4_f0_valid", 64'(mem_i_valid_o),    64'd0);
        check("t4_d_ack",    64'(mem_d_ack_o),      64'd1);
        check("t4_d_tag",    64'(mem_d_resp_tag_o), 64'd12);
        tick(1);
        check("t4_f1_valid", 64'(mem_i_valid_o), 64'd0);
        tick(1);
        check("t4_f2_valid", 64'(mem_i_valid_o), 64'd1);
        check("t4_f2_inst",  mem_i_inst_o,       64'hA5A5A5A55A5A5A5A);

        // Same-cycle write and fetch of 0x20 sees old data
        d_op(1'b0, 4'hF, 32'h20, 32'h11111111, 11'd0);
        d_op(1'b0, 4'hF, 32'h24, 32'h22222222, 11'd0);
        d_req(1'b0, 4'hF, 32'h20, 32'h99999999, 11'd13);
        mem_i_rd_i = 1'b1;
        mem_i_pc_i = 32'h20;
        tick(1);
        idle();
        mem_i_rd_i = 1'b1;
        tick(1);
        idle();
        tick(1);
        check("t5_old_valid", 64'(mem_i_valid_o), 64'd1);
        check("t5_old_inst",  mem_i_inst_o,       64'h1111111122222222);
        tick(1);
        check("t5_new_valid", 64'(mem_i_valid_o), 64'd1);
        check("t5_new_inst",  mem_i_inst_o,       64'h9999999922222222);

        // Reset with requests in flight drops their responses
        d_req(1'b1, 4'h0, 32'h0, 32'h0, 11'd14);
        mem_i_rd_i = 1'b1;
        mem_i_pc_i = 32'h0;
        tick(1);
        idle();
        rstn_i = 1'b0;
        #1;
        check("t6_rst_ack",   64'(mem_d_ack_o),   64'd0);
        check("t6_rst_valid", 64'(mem_i_valid_o), 64'd0);
        tick(1);
        rstn_i = 1'b1;
        tick(LAT);
        check("t6_no_ack",   64'(mem_d_ack_o),   64'd0);
        check("t6_no_valid", 64'(mem_i_valid_o), 64'd0);

`ifdef TCM_MEM_PARITY_EN
        mem_inject_par_i = 1'b1;
        d_op(1'b0, 4'hF, 32'h40, 32'h12345678, 11'd15);
        mem_inject_par_i = 1'b0;
        d_op(1'b1, 4'h0, 32'h40, 32'h0, 11'd16);
        check("t7_par_err", 64'(mem_d_error_o),   64'd1);
        check("t7_par_dat", 64'(mem_d_data_rd_o), 64'h12345678);
        d_op(1'b0, 4'hF, 32'h40, 32'h12345678, 11'd17);
        d_op(1'b1, 4'h0, 32'h40, 32'h0, 11'd18);
        check("t7_clean_err", 64'(mem_d_error_o), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
